// File: rtl/alloc_dispatcher_if.sv
// Request/alloc/error bundle for the allocation dispatcher.
//   req_valid_in / req_ready_out : per-requester handshake (ready is one-hot or zero)
//   req_id_in / req_bytes_in     : packed per-requester id and byte count
//   alloc_*_dsp_out              : single-cycle alloc pulse into the find table
//   fdt_blocked_in               : blocked flag returned by the find table
//   err_*_out                    : one-cycle error report
//   busy_out                     : dispatcher not idle
// master = requesters + find table side, slave = dispatcher.
interface alloc_dispatcher_if #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_WIDTH    = 8,
  parameter int unsigned BYTES_WIDTH = 13
);
  logic [NUM_REQ-1:0]             req_valid_in;
  logic [NUM_REQ-1:0]             req_ready_out;
  logic [NUM_REQ*ID_WIDTH-1:0]    req_id_in;
  logic [NUM_REQ*BYTES_WIDTH-1:0] req_bytes_in;
  logic                           alloc_valid_dsp_out;
  logic [ID_WIDTH-1:0]            alloc_id_dsp_out;
  logic [1:0]                     alloc_size_dsp_out;
  logic                           fdt_blocked_in;
  logic                           err_valid_out;
  logic [ID_WIDTH-1:0]            err_id_out;
  logic [1:0]                     err_code_out;
  logic                           busy_out;

  modport master (
    output req_valid_in, req_id_in, req_bytes_in, fdt_blocked_in,
    input  req_ready_out, alloc_valid_dsp_out, alloc_id_dsp_out, alloc_size_dsp_out,
    input  err_valid_out, err_id_out, err_code_out, busy_out
  );

  modport slave (
    input  req_valid_in, req_id_in, req_bytes_in, fdt_blocked_in,
    output req_ready_out, alloc_valid_dsp_out, alloc_id_dsp_out, alloc_size_dsp_out,
    output err_valid_out, err_id_out, err_code_out, busy_out
  );
endinterface

// File: rtl/alloc_dispatcher.sv
// Allocation-path front end. Round-robin arbitrates NUM_REQ alloc requesters,
// converts the accepted byte count to a size class (0=512,1=1K,2=2K,3=4K),
// issues a single-cycle alloc pulse to the find table, replays blocked allocs
// after RETRY_GAP idle cycles up to MAX_RETRY times, and reports malformed
// (code 1) or retry-exhausted (code 2) requests on the error channel.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : alloc_dispatcher_if.slave (request, alloc, blocked, error, busy)
// All outputs except req_ready_out are registered; ready is combinational and
// forced low while reset is asserted.
module alloc_dispatcher #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_WIDTH    = 8,
  parameter int unsigned BYTES_WIDTH = 13,
  parameter int unsigned RETRY_GAP   = 3,
  parameter int unsigned MAX_RETRY   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  alloc_dispatcher_if.slave bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CHECK,
    BACKOFF,
    ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       rr_q, rr_d;
  logic [CNT_W-1:0]       retry_q, retry_d;
  logic [CNT_W-1:0]       gap_q, gap_d;
  logic [ID_WIDTH-1:0]    cap_id_q, cap_id_d;
  logic [BYTES_WIDTH-1:0] cap_bytes_q, cap_bytes_d;

  logic                   alloc_valid_q, alloc_valid_d;
  logic [ID_WIDTH-1:0]    alloc_id_q, alloc_id_d;
  logic [1:0]             alloc_size_q, alloc_size_d;
  logic                   err_valid_q, err_valid_d;
  logic [ID_WIDTH-1:0]    err_id_q, err_id_d;
  logic [1:0]             err_code_q, err_code_d;
  logic                   busy_q, busy_d;

  logic [NUM_REQ-1:0]     ready;
  logic                   gnt_found;
  logic [PTR_W-1:0]       gnt_idx;

  logic [ID_WIDTH-1:0]    req_id    [NUM_REQ];
  logic [BYTES_WIDTH-1:0] req_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_id[g]    = bus.req_id_in[g*ID_WIDTH +: ID_WIDTH];
    assign req_bytes[g] = bus.req_bytes_in[g*BYTES_WIDTH +: BYTES_WIDTH];
  end

  // Full-width compare so out-of-range counts above 4096 are never aliased.
  function automatic logic [1:0] size_class(input logic [BYTES_WIDTH-1:0] b);
    logic [31:0] v;
    v = 32'(b);
    if (v <= 32'd512)       size_class = 2'd0;
    else if (v <= 32'd1024) size_class = 2'd1;
    else if (v <= 32'd2048) size_class = 2'd2;
    else                    size_class = 2'd3;
  endfunction

  function automatic logic bad_size(input logic [BYTES_WIDTH-1:0] b);
    logic [31:0] v;
    v = 32'(b);
    bad_size = (v == 32'd0) || (v > 32'd4096);
  endfunction

  // First valid requester at or above the rr pointer, wrapping.
  always_comb begin : p_grant
    int unsigned idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && bus.req_valid_in[PTR_W'(idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(idx);
      end
    end
  end

  // Outputs are registered by computing their next value from state_d, so the
  // alloc pulse lines up with the ISSUE cycle and the error pulse with ERR.
  always_comb begin : p_next
    state_d     = state_q;
    rr_d        = rr_q;
    retry_d     = retry_q;
    gap_d       = gap_q;
    cap_id_d    = cap_id_q;
    cap_bytes_d = cap_bytes_q;
    ready       = '0;
    err_valid_d = 1'b0;
    err_id_d    = '0;
    err_code_d  = '0;

    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          ready       = NUM_REQ'(1) << gnt_idx;
          cap_id_d    = req_id[gnt_idx];
          cap_bytes_d = req_bytes[gnt_idx];
          rr_d        = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
          if (bad_size(req_bytes[gnt_idx])) begin
            state_d     = ERR;
            err_valid_d = 1'b1;
            err_id_d    = req_id[gnt_idx];
            err_code_d  = 2'd1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = CHECK;
      CHECK: begin
        if (!bus.fdt_blocked_in) begin
          retry_d = '0;
          state_d = IDLE;
        end else if (retry_q < CNT_W'(MAX_RETRY)) begin
          retry_d = retry_q + CNT_W'(1);
          gap_d   = CNT_W'(RETRY_GAP);
          state_d = BACKOFF;
        end else begin
          state_d     = ERR;
          err_valid_d = 1'b1;
          err_id_d    = cap_id_q;
          err_code_d  = 2'd2;
        end
      end
      BACKOFF: begin
        gap_d = gap_q - CNT_W'(1);
        if (gap_q <= CNT_W'(1)) state_d = ISSUE;
      end
      ERR: begin
        retry_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    alloc_valid_d = (state_d == ISSUE);
    alloc_id_d    = alloc_valid_d ? cap_id_d : '0;
    alloc_size_d  = alloc_valid_d ? size_class(cap_bytes_d) : '0;
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_q          <= '0;
      retry_q       <= '0;
      gap_q         <= '0;
      cap_id_q      <= '0;
      cap_bytes_q   <= '0;
      alloc_valid_q <= 1'b0;
      alloc_id_q    <= '0;
      alloc_size_q  <= '0;
      err_valid_q   <= 1'b0;
      err_id_q      <= '0;
      err_code_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      retry_q       <= retry_d;
      gap_q         <= gap_d;
      cap_id_q      <= cap_id_d;
      cap_bytes_q   <= cap_bytes_d;
      alloc_valid_q <= alloc_valid_d;
      alloc_id_q    <= alloc_id_d;
      alloc_size_q  <= alloc_size_d;
      err_valid_q   <= err_valid_d;
      err_id_q      <= err_id_d;
      err_code_q    <= err_code_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.req_ready_out       = rst_n ? ready : '0;
  assign bus.alloc_valid_dsp_out = alloc_valid_q;
  assign bus.alloc_id_dsp_out    = alloc_id_q;
  assign bus.alloc_size_dsp_out  = alloc_size_q;
  assign bus.err_valid_out       = err_valid_q;
  assign bus.err_id_out          = err_id_q;
  assign bus.err_code_out        = err_code_q;
  assign bus.busy_out            = busy_q;

  a_alloc_err_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(alloc_valid_q && err_valid_q));
  a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_ready_out));
  a_ready_idle_only: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |-> (bus.req_ready_out == '0));

endmodule

// File: tb/tb_alloc_dispatcher.sv
module tb_alloc_dispatcher;

  localparam int unsigned NR   = 4;
  localparam int unsigned IW   = 8;
  localparam int unsigned BW   = 13;
  localparam int unsigned GAP  = 3;
  localparam int unsigned MAXR = 15;
  localparam int unsigned P    = GAP + 2;  // spacing between successive alloc pulses

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alloc_dispatcher_if #(.NUM_REQ(NR), .ID_WIDTH(IW), .BYTES_WIDTH(BW)) bus ();

  alloc_dispatcher #(
    .NUM_REQ(NR), .ID_WIDTH(IW), .BYTES_WIDTH(BW), .RETRY_GAP(GAP), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]      mask;
    logic [7:0]      base;
    logic [4*BW-1:0] bytes;
    int unsigned     k;       // number of blocked CHECK results before success
    bit              hold;    // keep valids asserted after the handshake
    int unsigned     g;       // expected grant
    logic [1:0]      size;
    logic [1:0]      code;
    int unsigned     pulses;  // expected number of alloc pulses
  } vec_t;

  vec_t        tbl[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned m_rr     = 0;
  string       tag      = "init";

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got 0x%0h expected 0x%0h", tag, name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*BW-1:0] mk(input int unsigned b0, input int unsigned b1,
                                         input int unsigned b2, input int unsigned b3);
    return {BW'(b3), BW'(b2), BW'(b1), BW'(b0)};
  endfunction

  function automatic void add(input logic [3:0] mask, input logic [7:0] base,
                              input logic [4*BW-1:0] bytes, input int unsigned k, input bit hold,
                              input int unsigned g, input logic [1:0] size, input logic [1:0] code,
                              input int unsigned pulses);
    vec_t v;
    v.mask = mask; v.base = base; v.bytes = bytes; v.k = k; v.hold = hold;
    v.g = g; v.size = size; v.code = code; v.pulses = pulses;
    tbl.push_back(v);
  endfunction

  task automatic drive_req(input logic [3:0] mask, input logic [7:0] base, input logic [4*BW-1:0] bytes);
    bus.req_valid_in = mask;
    bus.req_id_in    = {base + 8'd3, base + 8'd2, base + 8'd1, base};
    bus.req_bytes_in = bytes;
  endtask

  // Starts at the beginning of an IDLE cycle (c=0), returns at the start of the
  // next IDLE cycle. Timing is derived purely from the expected outcome.
  task automatic run_txn(input logic [3:0] mask, input logic [7:0] base, input logic [4*BW-1:0] bytes,
                         input int unsigned k, input bit hold, input int unsigned g,
                         input logic [1:0] size, input logic [1:0] code, input int unsigned pulses);
    int unsigned last, err_at, fin;
    logic [7:0]  eid;
    logic [3:0]  eready;
    bit          is_pulse, is_check, is_err;
    eid  = base + 8'(g);
    last = (pulses > 0) ? 1 + P * (pulses - 1) : 0;
    if (code == 2'd1) begin
      err_at = 1; fin = 2;
    end else if (code == 2'd2) begin
      err_at = last + 2; fin = last + 3;
    end else begin
      err_at = 0; fin = last + 2;
    end
    for (int unsigned c = 0; c < fin; c++) begin
      if (c == 0) drive_req(mask, base, bytes);
      else begin
        step();
        if (!hold) bus.req_valid_in = '0;
      end
      is_check = (pulses > 0) && (c >= 2) && ((c - 2) % P == 0) && ((c - 2) / P < pulses);
      // Outside CHECK cycles the blocked flag is noise and must be ignored.
      bus.fdt_blocked_in = is_check ? ((c - 2) / P < k) : 1'($urandom_range(0, 1));
      @(negedge clk);
      is_pulse = (pulses > 0) && (c >= 1) && ((c - 1) % P == 0) && ((c - 1) / P < pulses);
      is_err   = (err_at != 0) && (c == err_at);
      eready   = (c == 0) ? 4'(1 << g) : 4'b0;
      chk("ready", 32'(bus.req_ready_out), 32'(eready));
      chk("alloc_valid", 32'(bus.alloc_valid_dsp_out), 32'(is_pulse));
      if (is_pulse) begin
        chk("alloc_id", 32'(bus.alloc_id_dsp_out), 32'(eid));
        chk("alloc_size", 32'(bus.alloc_size_dsp_out), 32'(size));
      end
      chk("err_valid", 32'(bus.err_valid_out), 32'(is_err));
      if (is_err) begin
        chk("err_id", 32'(bus.err_id_out), 32'(eid));
        chk("err_code", 32'(bus.err_code_out), 32'(code));
      end
      chk("busy", 32'(bus.busy_out), 32'(c >= 1));
    end
    step();
    m_rr = (g + 1) % NR;
  endtask

  function automatic int unsigned rand_bytes();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 0;
    if (sel == 1) return $urandom_range(4097, 8191);
    if (sel <= 3) begin
      case ($urandom_range(0, 7))
        0: return 1;
        1: return 512;
        2: return 513;
        3: return 1024;
        4: return 1025;
        5: return 2048;
        6: return 2049;
        default: return 4096;
      endcase
    end
    return $urandom_range(1, 4096);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]      mask;
    logic [7:0]      base;
    logic [4*BW-1:0] bytes;
    int unsigned     barr [NR];
    int unsigned     k, g, b, q, pulses;
    logic [1:0]      size, code;
    bit              found, bad;

    // Ready must stay low during reset even with every requester valid.
    bus.req_valid_in   = '1;
    bus.req_id_in      = '0;
    bus.req_bytes_in   = '0;
    bus.fdt_blocked_in = 1'b1;
    tag = "reset";
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ready", 32'(bus.req_ready_out), 32'd0);
    chk("alloc_valid", 32'(bus.alloc_valid_dsp_out), 32'd0);
    chk("err_valid", 32'(bus.err_valid_out), 32'd0);
    chk("busy", 32'(bus.busy_out), 32'd0);
    chk("alloc_id", 32'(bus.alloc_id_dsp_out), 32'd0);
    chk("err_code", 32'(bus.err_code_out), 32'd0);
    step();
    rst_n = 1'b1;
    bus.req_valid_in = '0;
    m_rr = 0;

    //  mask     base   bytes per requester             k  hold g  size  code  pulses
    add(4'b1111, 8'hA0, mk(512, 1024, 2048, 4096),      0, 1,   0, 2'd0, 2'd0, 1);
    add(4'b1111, 8'hA0, mk(512, 1024, 2048, 4096),      0, 1,   1, 2'd1, 2'd0, 1);
    add(4'b1111, 8'hA0, mk(512, 1024, 2048, 4096),      0, 1,   2, 2'd2, 2'd0, 1);
    add(4'b1111, 8'hA0, mk(512, 1024, 2048, 4096),      0, 1,   3, 2'd3, 2'd0, 1);
    add(4'b1111, 8'hA0, mk(512, 1024, 2048, 4096),      0, 1,   0, 2'd0, 2'd0, 1);
    add(4'b0001, 8'h11, mk(700, 700, 700, 700),         0, 0,   0, 2'd1, 2'd0, 1);
    add(4'b0100, 8'h20, mk(0, 0, 0, 0),                 0, 0,   2, 2'd0, 2'd1, 0);
    add(4'b0100, 8'h30, mk(4097, 4097, 4097, 4097),     0, 0,   2, 2'd0, 2'd1, 0);
    add(4'b1000, 8'h40, mk(1, 1, 1, 1),                 1, 0,   3, 2'd0, 2'd0, 2);
    add(4'b0010, 8'h50, mk(513, 513, 513, 513),        17, 0,   1, 2'd1, 2'd2, 16);
    add(4'b1011, 8'h60, mk(2049, 2049, 2049, 2049),     0, 0,   3, 2'd3, 2'd0, 1);
    add(4'b0110, 8'h70, mk(1025, 1025, 1025, 1025),    15, 0,   1, 2'd2, 2'd0, 16);
    add(4'b0001, 8'h80, mk(4096, 4096, 4096, 4096),     0, 0,   0, 2'd3, 2'd0, 1);
    add(4'b0011, 8'h90, mk(8191, 8191, 8191, 8191),     0, 0,   1, 2'd0, 2'd1, 0);
    add(4'b0101, 8'hB0, mk(1024, 1024, 1024, 1024),     2, 0,   2, 2'd1, 2'd0, 3);

    foreach (tbl[i]) begin
      tag = $sformatf("vec%0d", i);
      run_txn(tbl[i].mask, tbl[i].base, tbl[i].bytes, tbl[i].k, tbl[i].hold,
              tbl[i].g, tbl[i].size, tbl[i].code, tbl[i].pulses);
    end

    // Reset while in BACKOFF: outputs drop at once, request is not replayed,
    // and arbitration restarts from requester 0.
    tag = "rst_backoff";
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    m_rr = 0;
    drive_req(4'b1010, 8'h50, mk(100, 100, 100, 100));
    bus.fdt_blocked_in = 1'b0;
    @(negedge clk);
    chk("ready", 32'(bus.req_ready_out), 32'b0010);
    step();
    @(negedge clk);
    chk("alloc_valid", 32'(bus.alloc_valid_dsp_out), 32'd1);
    chk("alloc_id", 32'(bus.alloc_id_dsp_out), 32'h51);
    step();
    bus.fdt_blocked_in = 1'b1;
    @(negedge clk);
    chk("busy", 32'(bus.busy_out), 32'd1);
    step();
    bus.fdt_blocked_in = 1'b0;
    @(negedge clk);
    chk("busy", 32'(bus.busy_out), 32'd1);
    chk("alloc_valid", 32'(bus.alloc_valid_dsp_out), 32'd0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ready", 32'(bus.req_ready_out), 32'd0);
    chk("alloc_valid", 32'(bus.alloc_valid_dsp_out), 32'd0);
    chk("alloc_id", 32'(bus.alloc_id_dsp_out), 32'd0);
    chk("err_valid", 32'(bus.err_valid_out), 32'd0);
    chk("busy", 32'(bus.busy_out), 32'd0);
    step();
    rst_n = 1'b1;
    run_txn(4'b1010, 8'h50, mk(100, 100, 100, 100), 0, 1, 1, 2'd0, 2'd0, 1);

    // Random requests against an outcome-level model.
    for (int r = 0; r < 60; r++) begin
      tag  = $sformatf("rnd%0d", r);
      mask = 4'($urandom_range(1, 15));
      base = 8'($urandom);
      for (int i = 0; i < NR; i++) barr[i] = rand_bytes();
      bytes = mk(barr[0], barr[1], barr[2], barr[3]);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: k = 0;
        6, 7:             k = $urandom_range(1, 3);
        default:          k = $urandom_range(14, 17);
      endcase
      found = 1'b0;
      g = 0;
      for (int unsigned i = 0; i < NR; i++) begin
        if (!found && mask[(m_rr + i) % NR]) begin
          found = 1'b1;
          g = (m_rr + i) % NR;
        end
      end
      b    = barr[g];
      bad  = (b == 0) || (b > 4096);
      size = 2'd0;
      if (!bad) begin
        q = (b - 1) / 512;
        size = (q == 0) ? 2'd0 : (q == 1) ? 2'd1 : (q < 4) ? 2'd2 : 2'd3;
      end
      code   = bad ? 2'd1 : ((k > MAXR) ? 2'd2 : 2'd0);
      pulses = bad ? 0 : ((k > MAXR) ? MAXR + 1 : k + 1);
      run_txn(mask, base, bytes, k, 1'($urandom_range(0, 1)), g, size, code, pulses);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alloc_dispatcher.md
Name: alloc_dispatcher

Overview:
- Front end of the allocation path. It arbitrates alloc requests from NUM_REQ requesters round-robin.
- Each request byte count is converted to an aligned size class, then issued as a single-cycle alloc pulse into the find-table stage.
- When the find table reports blocked, the dispatcher holds the request and replays it after a back-off, up to a retry limit.
- Malformed and exhausted requests are reported on an error channel.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_WIDTH, 8, request id width
BYTES_WIDTH, 13, request byte-count width (max 4096)
RETRY_GAP, 3, idle cycles between a blocked result and the reissue (1..15)
MAX_RETRY, 15, reissues allowed before the request is dropped with an error (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid_in  in  NUM_REQ  per-requester request valid
req_ready_out  out  NUM_REQ  per-requester ready; one-hot or zero
req_id_in  in  NUM_REQ*ID_WIDTH  packed ids; requester i at [i*ID_WIDTH +: ID_WIDTH]
req_bytes_in  in  NUM_REQ*BYTES_WIDTH  packed byte counts
alloc_valid_dsp_out  out  1  alloc pulse to find table
alloc_id_dsp_out  out  ID_WIDTH  id of issued alloc
alloc_size_dsp_out  out  2  size class: 0=512, 1=1K, 2=2K, 3=4K
fdt_blocked_in  in  1  blocked flag from find table
err_valid_out  out  1  one-cycle error pulse
err_id_out  out  ID_WIDTH  id of failed request
err_code_out  out  2  1=bad size, 2=retries exhausted
busy_out  out  1  high whenever state != IDLE

Behaviour:
Reset and outputs:
- Asynchronous reset clears state to IDLE, the rr pointer to 0, the retry counter to 0, and the captured request.
- All outputs are registered and reset to 0, except req_ready_out, which is combinational and is 0 during reset.
- Reset mid-operation drops the captured request silently. No error is raised and the request is not replayed.

State machine (IDLE, ISSUE, CHECK, BACKOFF, ERR):
- IDLE: the grant is the first requester with req_valid_in high, searching upward from the rr pointer with wrap-around.
  - req_ready_out[grant] = 1; all other ready bits = 0.
  - On valid&ready (cycle T), capture id and bytes and set rr pointer = grant+1 mod NUM_REQ.
  - Size mapping: 1..512 gives 0; 513..1024 gives 1; 1025..2048 gives 2; 2049..4096 gives 3. Compare the full BYTES_WIDTH value.
  - If bytes = 0 or > 4096, go to ERR with code 1. Otherwise go to ISSUE.
- ISSUE: alloc_valid_dsp_out = 1 for exactly this cycle (T+1), with the captured id and size. Next state is CHECK.
- CHECK (T+2): sample fdt_blocked_in. The find table registers its blocked flag the cycle after the alloc pulse.
  - blocked = 0: success. Clear the retry counter and go to IDLE.
  - blocked = 1, retry counter < MAX_RETRY: increment the counter, load the gap counter with RETRY_GAP, and go to BACKOFF.
  - blocked = 1, retry counter = MAX_RETRY: go to ERR with code 2.
- BACKOFF: decrement the gap counter each cycle. When it reaches 0, go to ISSUE and reissue the same id and size. fdt_blocked_in is ignored here.
- ERR: err_valid_out = 1 for one cycle with the captured id and code. Clear the retry counter and go to IDLE.

Throughput and timing:
- Minimum 3 cycles per successful request (IDLE accept, ISSUE, CHECK). The next accept can occur in the cycle after CHECK.
- No new request is accepted outside IDLE; all ready bits are 0 there.
- fdt_blocked_in is never sampled in IDLE. A stale high level left over from an earlier request is ignored.
- alloc_valid_dsp_out and err_valid_out are never high in the same cycle.
- Simultaneous valids: only the grant is accepted. Others stay pending and must hold their valid, id and bytes until their own ready.
- Requester valid deassertion without a handshake is allowed. The arbiter re-evaluates every IDLE cycle.

Test Plan:
- Single requester 0, id=0x11, bytes=700, fdt_blocked_in=0 -> alloc pulse at T+1 with id 0x11, size 1; busy_out high for 2 cycles; back in IDLE at T+3.
- All 4 requesters valid continuously with bytes 512/1024/2048/4096 -> grant order 0,1,2,3,0; sizes 0,1,2,3; each alloc pulse exactly one cycle; ready never high outside IDLE.
- bytes=0 and bytes=4097 on requester 2 -> no alloc pulse; err_valid_out pulse with code 1 and matching id; rr pointer advances to 3.
- fdt_blocked_in=1 for first CHECK only, RETRY_GAP=3 -> first pulse T+1, reissue of same id/size at T+6 (CHECK T+2, BACKOFF T+3..T+5), success at T+7.
- fdt_blocked_in held at 1, MAX_RETRY=15 -> 16 alloc pulses total, then err code 2 with that id; next requester accepted immediately after.
- rst_n asserted during BACKOFF -> all outputs 0 at once; after release, the pending requester is re-accepted from IDLE with rr pointer 0 and no replay of the dropped request.
